// File: rtl/toggle_hs_receiver.sv
// -----------------------------------------------------------------------------
// toggle_hs_receiver
//
// Receiving end of a two-phase (toggle) request/acknowledge link. The request
// toggle is synchronised into Clk, the bundled data word is captured into a
// small first-word-fall-through FIFO, and the block answers by toggling its
// own acknowledge flop. While the FIFO is full the acknowledge is withheld,
// which is how backpressure reaches the initiator.
//
// Ports:
//   Clk        clock, all state updates on the rising edge
//   Rst        asynchronous, active-high reset
//   Req_Tgl    request toggle from initiator; each level change = one word
//   Data_In    bundled data, stable from Req_Tgl change until Ack_Tgl change
//   Ack_Tgl    acknowledge toggle; flips once per accepted word
//   Out_Valid  FIFO head holds a word
//   Out_Data   FIFO head word (fall-through, combinational from storage)
//   Out_Ready  downstream accepts the head word this cycle
//   Count      number of words currently stored
//   Busy       handshake FSM is not idle
// -----------------------------------------------------------------------------
module toggle_hs_receiver #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  localparam int CW         = $clog2(DEPTH + 1),
  localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Req_Tgl,
  input  logic [DATA_W-1:0] Data_In,
  output logic              Ack_Tgl,
  output logic              Out_Valid,
  output logic [DATA_W-1:0] Out_Data,
  input  logic              Out_Ready,
  output logic [CW-1:0]     Count,
  output logic              Busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    STALL  = 2'd2
  } state_t;

  state_t                 state_reg;
  state_t                 state_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   req_sync;
  logic                   req_seen_reg;
  logic                   ack_reg;
  logic [AW-1:0]          wr_ptr_reg;
  logic [AW-1:0]          rd_ptr_reg;
  logic [CW-1:0]          count_reg;
  logic [DATA_W-1:0]      mem_reg [DEPTH];
  logic                   pending;
  logic                   full;
  logic                   wr_en;
  logic                   pop;

  // ---------------------------------------------------------------------------
  // Request synchroniser: Req_Tgl enters at bit 0, req_sync is the last flop.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], Req_Tgl};
    end
  end

  assign req_sync = sync_reg[SYNC_STAGES-1];
  assign pending  = (req_sync != req_seen_reg);
  assign full     = (count_reg == CW'(DEPTH));

  // The word is committed on the edge that leaves ACCEPT; entry into ACCEPT
  // is only ever granted with a free slot, so wr_en never hits a full FIFO.
  assign wr_en    = (state_reg == ACCEPT);
  assign pop      = Out_Valid && Out_Ready;

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (pending) begin
          state_next = full ? STALL : ACCEPT;
        end
      end
      STALL: begin
        if (!full) begin
          state_next = ACCEPT;
        end
      end
      ACCEPT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Acknowledge side: remember which request level has been served and flip
  // the ack once per accepted word.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      req_seen_reg <= 1'b0;
      ack_reg      <= 1'b0;
    end else if (wr_en) begin
      req_seen_reg <= req_sync;
      ack_reg      <= ~ack_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage, one register per entry so each can be cleared on reset.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
          mem_reg[gi] <= '0;
        end else if (wr_en && (wr_ptr_reg == AW'(gi))) begin
          mem_reg[gi] <= Data_In;
        end
      end
    end
  endgenerate

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
    end
  end

  // Simultaneous write and pop leave the occupancy unchanged.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      count_reg <= '0;
    end else begin
      case ({wr_en, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign Ack_Tgl   = ack_reg;
  assign Count     = count_reg;
  assign Out_Valid = (count_reg != '0);
  assign Out_Data  = mem_reg[rd_ptr_reg];
  assign Busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_toggle_hs_receiver.sv
module tb_toggle_hs_receiver;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int SS     = 2;

  logic              Clk = 1'b0;
  logic              Rst;
  logic              Req_Tgl;
  logic [DATA_W-1:0] Data_In;
  logic              Ack_Tgl;
  logic              Out_Valid;
  logic [DATA_W-1:0] Out_Data;
  logic              Out_Ready;
  logic [2:0]        Count;
  logic              Busy;

  toggle_hs_receiver #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .Clk(Clk), .Rst(Rst), .Req_Tgl(Req_Tgl), .Data_In(Data_In),
    .Ack_Tgl(Ack_Tgl), .Out_Valid(Out_Valid), .Out_Data(Out_Data),
    .Out_Ready(Out_Ready), .Count(Count), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // Reference model: words issued in order, words accepted, words popped.
  logic [DATA_W-1:0] exp_q[$];
  int sent_count = 0;
  int ack_count  = 0;
  int pop_count  = 0;
  logic last_ack = 1'b0;
  bit mon_en = 1'b0;
  bit rand_done = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  // Monitor: stored words = accepted - popped; every pop is compared with
  // the oldest word issued.
  always @(negedge Clk) begin
    if (!Rst && mon_en) begin
      int model;
      if (Ack_Tgl !== last_ack) begin
        ack_count++;
        last_ack = Ack_Tgl;
        check("ack_not_ahead_of_requests", (ack_count <= sent_count), 1);
      end
      model = ack_count - pop_count;
      check("count", Count, model);
      check("out_valid", Out_Valid, (model != 0));
      if (Out_Valid && Out_Ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_data: got %0h expected no word at %0t", Out_Data, $time);
        end else begin
          check("pop_data", Out_Data, exp_q.pop_front());
        end
        pop_count++;
      end
    end
  end

  task automatic issue(input logic [DATA_W-1:0] d);
    Data_In = d;
    Req_Tgl = ~Req_Tgl;
    exp_q.push_back(d);
    sent_count++;
  endtask

  // Counts edges until Ack_Tgl leaves 'old'; -1 on timeout.
  task automatic wait_ack(input logic old, input int budget, output int edges);
    edges = 0;
    while (Ack_Tgl === old && edges < budget) begin
      @(posedge Clk); #1;
      edges++;
    end
    if (Ack_Tgl === old) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got no ack after %0d edges expected a flip", edges);
      edges = -1;
    end
  endtask

  task automatic drain();
    int n = 0;
    Out_Ready = 1'b1;
    while ((exp_q.size() != 0 || Out_Valid !== 1'b0) && n < 200) begin
      @(posedge Clk); #1;
      n++;
    end
    check("drain_done", (exp_q.size() == 0 && Out_Valid === 1'b0), 1);
    Out_Ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    logic old;

    Rst = 1'b1; Req_Tgl = 1'b0; Data_In = '0; Out_Ready = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_ack", Ack_Tgl, 0);
    check("rst_valid", Out_Valid, 0);
    check("rst_count", Count, 0);
    check("rst_busy", Busy, 0);
    check("rst_data", Out_Data, 0);
    Rst = 1'b0;
    mon_en = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); #1;
      check("idle_ack", Ack_Tgl, 0);
      check("idle_busy", Busy, 0);
    end

    // Single transfer: issued just after edge n-1, so the flip lands on the
    // (SS+2)-th edge counted from the issue, i.e. SS+1 edges after sampling.
    issue(8'hA5);
    wait_ack(1'b0, 50, e);
    check("single_latency", e, SS + 2);
    check("single_ack", Ack_Tgl, 1);
    check("single_data", Out_Data, 8'hA5);
    Out_Ready = 1'b1;
    @(posedge Clk); #1;
    Out_Ready = 1'b0;
    check("single_count_after_pop", Count, 0);

    // Fill to full with no drain
    for (int i = 1; i <= 4; i++) begin
      old = Ack_Tgl;
      issue(8'(i));
      wait_ack(old, 50, e);
      check("fill_latency", e, SS + 2);
    end
    check("fill_count", Count, 4);

    // Fifth word must stall
    old = Ack_Tgl;
    issue(8'h05);
    for (int i = 1; i <= 20; i++) begin
      @(posedge Clk); #1;
      check("stall_ack_held", Ack_Tgl, old);
      if (i >= 3) check("stall_busy", Busy, 1);
    end

    // One pop frees a slot; the stalled word is written two edges later.
    Out_Ready = 1'b1;
    @(posedge Clk); #1;
    Out_Ready = 1'b0;
    wait_ack(old, 50, e);
    check("stall_release_latency", e, 2);
    check("stall_release_count", Count, 4);
    drain();

    // Wrap with simultaneous write and pop
    Out_Ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      old = Ack_Tgl;
      issue(8'(8'h10 + i));
      wait_ack(old, 50, e);
      check("wrap_latency", e, SS + 2);
      check("wrap_count_max", (Count <= 1), 1);
    end
    drain();

    // Reset in the middle of ACCEPT with two words stored
    for (int i = 0; i < 2; i++) begin
      old = Ack_Tgl;
      issue(8'(8'h21 + i));
      wait_ack(old, 50, e);
    end
    check("pre_rst_count", Count, 2);
    issue(8'h23);
    repeat (3) @(posedge Clk);
    #1;
    check("pre_rst_busy", Busy, 1);
    check("pre_rst_req", Req_Tgl, 1);
    mon_en = 1'b0;
    Rst = 1'b1;
    #1;
    check("async_rst_ack", Ack_Tgl, 0);
    check("async_rst_valid", Out_Valid, 0);
    check("async_rst_count", Count, 0);
    check("async_rst_busy", Busy, 0);
    check("async_rst_data", Out_Data, 0);
    exp_q.delete();
    sent_count = 0; ack_count = 0; pop_count = 0; last_ack = 1'b0;
    @(posedge Clk); #1;
    Rst = 1'b0;
    mon_en = 1'b1;
    // Req_Tgl is still high: one pending request carrying the held word.
    exp_q.push_back(Data_In);
    sent_count = 1;
    wait_ack(1'b0, 50, e);
    check("post_rst_latency", e, SS + 2);
    check("post_rst_ack", Ack_Tgl, 1);
    drain();

    // Randomised traffic with random downstream backpressure
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          int gap = $urandom_range(0, 3);
          logic o;
          repeat (gap) begin @(posedge Clk); #1; end
          o = Ack_Tgl;
          issue(8'($urandom));
          wait_ack(o, 500, e);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge Clk); #1;
          Out_Ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    drain();

    repeat (3) @(posedge Clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/toggle_hs_receiver.md
Name: toggle_hs_receiver

Overview:
Receiving end of a two-phase (toggle) request/acknowledge link. The initiator drives its request line from a toggle flip-flop and holds bundled data stable until acknowledged. This block synchronises the request toggle, captures the data word into a small first-word-fall-through FIFO, and answers by toggling its own acknowledge flip-flop. Downstream logic drains the FIFO with a valid/ready handshake.

Parameters:
DATA_W, 8, width of bundled data word
DEPTH, 4, FIFO entries (power of 2, >= 2)
SYNC_STAGES, 2, flops in the Req_Tgl synchroniser (>= 2)

Ports:
Clk  in  1  clock, all state updates on posedge
Rst  in  1  asynchronous, active-high reset
Req_Tgl  in  1  request toggle from initiator; each level change = one new word
Data_In  in  DATA_W  bundled data; stable from Req_Tgl change until Ack_Tgl change
Ack_Tgl  out  1  acknowledge toggle; flips once per accepted word
Out_Valid  out  1  FIFO head holds a word
Out_Data  out  DATA_W  FIFO head word (fall-through)
Out_Ready  in  1  downstream accepts head this cycle
Count  out  $clog2(DEPTH+1)  words currently stored
Busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, immediate): sync chain=0, req_seen=0, Ack_Tgl=0, FSM=IDLE, rd/wr pointers=0, Count=0, storage=0, Out_Valid=0, Out_Data=0, Busy=0.
- Synchroniser: Req_Tgl passes through SYNC_STAGES flops -> req_sync. pending = (req_sync != req_seen).
- FSM states: IDLE, ACCEPT, STALL.
  - IDLE: pending & Count<DEPTH -> ACCEPT; pending & Count==DEPTH -> STALL; else stay.
  - STALL: Count<DEPTH -> ACCEPT; else stay.
  - ACCEPT: exit edge writes Data_In to mem[wr_ptr], increments wr_ptr (wraps mod DEPTH), sets req_seen<=req_sync, flips Ack_Tgl. Always -> IDLE.
- Latency: Req_Tgl change sampled at edge n -> req_sync changes at edge n+SYNC_STAGES-1 -> ACCEPT entered at edge n+SYNC_STAGES -> Ack_Tgl flips and word written at edge n+SYNC_STAGES+1. Peak throughput is one word per round-trip. There is no back-to-back acceptance without a new toggle.
- FIFO read: Out_Valid = (Count!=0). Out_Data = mem[rd_ptr] (combinational from storage). A pop occurs when Out_Valid & Out_Ready, which increments rd_ptr (wraps mod DEPTH).
- Count: +1 on write only, -1 on pop only, unchanged on simultaneous write+pop. It never exceeds DEPTH and never goes below 0. Out_Ready with Out_Valid=0 is ignored.
- Full: no write and no Ack_Tgl flip while full, so backpressure reaches the initiator through the withheld ack. A pop in STALL frees a slot, and ACCEPT follows on the next edge.
- Multiple toggles: the protocol forbids a second Req_Tgl change before Ack_Tgl flips. If it happens anyway, req_sync may return to req_seen and the request is silently dropped. This is not flagged.
- Busy = (state != IDLE).
- Reset mid-operation: all state clears at once, and an in-flight word is lost. After release, if Req_Tgl is 1 it is treated as one pending request (req_seen=0). The initiator is expected to share Rst.

Test Plan:
- Reset release, Req_Tgl=0 held 10 cycles -> Ack_Tgl=0, Out_Valid=0, Count=0, Busy=0 throughout.
- Single transfer: Data_In=8'hA5, Req_Tgl 0->1 -> Ack_Tgl 0->1 exactly SYNC_STAGES+1 edges later. Out_Valid=1, Out_Data=8'hA5, Count=1. With Out_Ready=1 for one cycle -> Count=0, Out_Valid=0.
- Fill with Out_Ready=0: words 8'h01..8'h04 each sent after the prior ack -> Count=4. A fifth toggle with 8'h05 -> Busy=1 (STALL), Ack_Tgl unchanged for 20 cycles.
- Drain from full-stall: assert Out_Ready for one cycle -> Out_Data=8'h01 popped. Two edges later 8'h05 is written and Ack_Tgl flips. Continuous drain then yields 8'h02, 03, 04, 05 in order.
- Wrap and simultaneous events: 10 transfers 8'h10..8'h19 with Out_Ready=1 held -> all appear in order, Count never exceeds 1. Pointers wrap past DEPTH, Count unchanged on write+pop edges.
- Async Rst pulsed mid-ACCEPT with Count=2 -> outputs clear immediately without a clock edge. After release with Req_Tgl=1, one transfer is accepted and Ack_Tgl goes 0->1.
